// File: rtl/mpf_to_buffer_sm_matrix_if.sv
// ---------------------------------------------------------------------------
// mpf_to_buffer_sm_matrix_if
//   Bundles every non-clock/reset signal of the matrix-multiply read stage:
//   the control handshake (run/M/K/done), the MPF channel-0 request and
//   response signals, and the input line buffer push port.
//
//   Request header layout (HDR_W = CL_ADDR_W + 25 bits, MSB first):
//     addr_is_virtual(1) | vc_sel(2) | cl_len(2) | req_type(4) |
//     address(CL_ADDR_W) | mdata(16)
//   c0 response: c0Rx_rspValid, c0Rx_respType (4'h0 = read line),
//   c0Rx_data (512-bit line).
//
//   Modports:
//     master - the read stage (drives requests, pushes, done)
//     slave  - the environment (control, MPF shim, line buffer)
// ---------------------------------------------------------------------------
interface mpf_to_buffer_sm_matrix_if #(
  parameter int CNT_W     = 7,
  parameter int CL_ADDR_W = 42,
  parameter int DATA_W    = 512
);
  localparam int HDR_W = CL_ADDR_W + 25;

  logic                 run;
  logic [31:0]          M;
  logic [31:0]          K;
  logic                 done;
  logic [CL_ADDR_W-1:0] first_clAddr;
  logic                 c0TxAlmFull;
  logic                 c0TxValid;
  logic [HDR_W-1:0]     reqMemHdr;
  logic                 c0Rx_rspValid;
  logic [3:0]           c0Rx_respType;
  logic [DATA_W-1:0]    c0Rx_data;
  logic                 buffer_wr_enable;
  logic [DATA_W-1:0]    buffer_wr_data;
  logic [CNT_W-1:0]     buffer_used;

  modport master (
    input  run, M, K, first_clAddr, c0TxAlmFull,
           c0Rx_rspValid, c0Rx_respType, c0Rx_data, buffer_used,
    output done, c0TxValid, reqMemHdr, buffer_wr_enable, buffer_wr_data
  );

  modport slave (
    output run, M, K, first_clAddr, c0TxAlmFull,
           c0Rx_rspValid, c0Rx_respType, c0Rx_data, buffer_used,
    input  done, c0TxValid, reqMemHdr, buffer_wr_enable, buffer_wr_data
  );
endinterface

// File: rtl/mpf_to_buffer_sm_matrix.sv
// ---------------------------------------------------------------------------
// mpf_to_buffer_sm_matrix
//   Upstream read stage of the matrix-multiply datapath. On a run pulse it
//   reads (M*K)/16 consecutive cache lines starting at first_clAddr through
//   MPF channel 0 and pushes each returned line into the input line buffer.
//   A request is only issued when the line it fetches is guaranteed a slot
//   in the buffer, so the buffer cannot overflow.
//
//   Ports:
//     clk    - clock
//     reset  - asynchronous active-low reset
//     bus    - master view of mpf_to_buffer_sm_matrix_if
//              (run/M/K/done, c0 request/response, buffer push/occupancy)
// ---------------------------------------------------------------------------
module mpf_to_buffer_sm_matrix #(
  parameter int BUFFER_DEPTH = 64,
  parameter int CNT_W        = $clog2(BUFFER_DEPTH) + 1,
  parameter int CL_ADDR_W    = 42
) (
  input  logic                       clk,
  input  logic                       reset,
  mpf_to_buffer_sm_matrix_if.master  bus
);

  localparam int DATA_W = 512;
  localparam int HDR_W  = CL_ADDR_W + 25;
  localparam int LEN_W  = 60;

  localparam logic [3:0]   REQ_RDLINE_I = 4'h2;
  localparam logic [3:0]   RSP_RDLINE   = 4'h0;
  localparam logic [CNT_W:0] DEPTH_C    = (CNT_W+1)'(BUFFER_DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  // Read-line request, virtual address, VA channel, single line, mdata 0.
  function automatic logic [HDR_W-1:0] gen_req_hdr(input logic [CL_ADDR_W-1:0] addr);
    return {1'b1, 2'b00, 2'b00, REQ_RDLINE_I, addr, 16'h0000};
  endfunction

  function automatic logic is_read_rsp(input logic vld, input logic [3:0] rtype);
    return vld && (rtype == RSP_RDLINE);
  endfunction

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     req_cnt_q, req_cnt_d;
  logic [LEN_W-1:0]     rsp_cnt_q, rsp_cnt_d;
  logic [CL_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     out_q, out_d;
  logic                 tx_vld_q;
  logic [HDR_W-1:0]     hdr_q;
  logic                 wr_en_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic                 credit_q;

  logic [63:0]          prod;
  logic [CNT_W:0]       occ;
  logic                 req_fire;
  logic                 rsp_fire;

  assign prod = {32'b0, bus.M} * {32'b0, bus.K};
  // Lines either in flight or already sitting in the buffer.
  assign occ  = {1'b0, out_q} + {1'b0, bus.buffer_used};

  assign req_fire = (state_q == RUN) && (req_cnt_q < len_q) &&
                    !bus.c0TxAlmFull && (occ < DEPTH_C);
  assign rsp_fire = (state_q == RUN) &&
                    is_read_rsp(bus.c0Rx_rspValid, bus.c0Rx_respType);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    addr_d    = addr_q;
    // A credit comes back the cycle after a push, when buffer_used
    // starts counting that line instead.
    out_d     = out_q + CNT_W'(req_fire) - CNT_W'(credit_q);

    if (req_fire) begin
      addr_d    = addr_q + CL_ADDR_W'(1);
      req_cnt_d = req_cnt_q + LEN_W'(1);
    end
    if (rsp_fire) begin
      rsp_cnt_d = rsp_cnt_q + LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d   = RUN;
          len_d     = LEN_W'(prod >> 4);
          addr_d    = bus.first_clAddr;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          out_d     = '0;
        end
      end
      RUN: begin
        if (rsp_cnt_q >= len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      addr_q    <= '0;
      out_q     <= '0;
      tx_vld_q  <= 1'b0;
      hdr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      credit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      addr_q    <= addr_d;
      out_q     <= out_d;
      // Request stage: header carries the address before increment.
      tx_vld_q  <= req_fire;
      if (req_fire) hdr_q <= gen_req_hdr(addr_q);
      // Push stage: returned line goes straight to the buffer.
      wr_en_q   <= rsp_fire;
      if (rsp_fire) wr_data_q <= bus.c0Rx_data;
      // Credit stage: trails the push by one cycle.
      credit_q  <= wr_en_q;
    end
  end

  assign bus.done             = (state_q == IDLE);
  assign bus.c0TxValid        = tx_vld_q;
  assign bus.reqMemHdr        = hdr_q;
  assign bus.buffer_wr_enable = wr_en_q;
  assign bus.buffer_wr_data   = wr_data_q;

endmodule

// File: tb/tb_mpf_to_buffer_sm_matrix.sv
module tb_mpf_to_buffer_sm_matrix;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int AW    = 42;
  localparam int HW    = AW + 25;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mpf_to_buffer_sm_matrix_if #(.CNT_W(CNT_W), .CL_ADDR_W(AW)) bus ();

  mpf_to_buffer_sm_matrix #(.BUFFER_DEPTH(DEPTH), .CNT_W(CNT_W), .CL_ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  logic [AW-1:0]  req_addr[$];
  logic [HW-1:0]  req_hdr[$];
  int             req_cyc[$];
  logic [511:0]   push_data[$];
  int             push_cyc[$];
  pend_t          pend[$];
  int             done_rise_cyc = 0;
  int             done_low_cnt = 0;
  logic           done_prev = 1'b1;
  bit             rsp_en = 1'b1;
  int             inject_req = 0;
  int             inject_ack = 0;

  function automatic logic [511:0] line_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = a[31:0] ^ 32'hC0DE_0000;
    return {16{w}};
  endfunction

  function automatic logic [HW-1:0] hdr_of(input logic [AW-1:0] a);
    return {1'b1, 2'b00, 2'b00, 4'h2, a, 16'h0000};
  endfunction

  // Monitor plus MPF response model: responses come back in order,
  // 5 cycles after the request is seen.
  always @(negedge clk) begin
    if (bus.c0TxValid) begin
      req_hdr.push_back(bus.reqMemHdr);
      req_addr.push_back(bus.reqMemHdr[16 +: AW]);
      req_cyc.push_back(cyc);
      pend.push_back('{addr: bus.reqMemHdr[16 +: AW], due: cyc + 5});
    end
    if (bus.buffer_wr_enable) begin
      push_data.push_back(bus.buffer_wr_data);
      push_cyc.push_back(cyc);
    end
    if (bus.done && !done_prev) done_rise_cyc = cyc;
    if (!bus.done) done_low_cnt++;
    done_prev = bus.done;

    if (inject_req != inject_ack) begin
      bus.c0Rx_rspValid = 1'b1;
      bus.c0Rx_respType = 4'h1;
      bus.c0Rx_data     = '1;
      inject_ack++;
    end else if (rsp_en && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.c0Rx_rspValid = 1'b1;
      bus.c0Rx_respType = 4'h0;
      bus.c0Rx_data     = line_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.c0Rx_rspValid = 1'b0;
      bus.c0Rx_respType = 4'h0;
      bus.c0Rx_data     = '0;
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_run(input logic [31:0] m, input logic [31:0] k, input logic [AW-1:0] a);
    step();
    bus.M = m;
    bus.K = k;
    bus.first_clAddr = a;
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    chk({name, " done"}, 512'(bus.done), 512'(1));
  endtask

  // Checks n delivered lines starting at request/push log offsets br/bp.
  task automatic chk_lines(input string name, input int br, input int bp,
                           input logic [AW-1:0] a, input int n);
    logic [AW-1:0] ea;
    chk($sformatf("%s reqs", name), 512'(req_addr.size() - br), 512'(n));
    chk($sformatf("%s pushes", name), 512'(push_data.size() - bp), 512'(n));
    if (req_addr.size() - br == n && push_data.size() - bp == n) begin
      for (int i = 0; i < n; i++) begin
        ea = a + AW'(i);
        chk($sformatf("%s hdr%0d", name, i), 512'(req_hdr[br+i]), 512'(hdr_of(ea)));
        chk($sformatf("%s data%0d", name, i), push_data[bp+i], line_of(ea));
      end
      if (n > 0)
        chk($sformatf("%s done_rise", name), 512'(done_rise_cyc), 512'(push_cyc[bp+n-1] + 1));
    end
  endtask

  typedef struct {
    logic [31:0]   m;
    logic [31:0]   k;
    logic [AW-1:0] addr;
    int            lines;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int br, bp, dl, rel, max_occ, occ;

    vecs[0] = '{m: 32'd4,  k: 32'd16, addr: 42'h1000,          lines: 4};
    vecs[1] = '{m: 32'd1,  k: 32'd32, addr: 42'h3FF_FFFF_FFFF, lines: 2};
    vecs[2] = '{m: 32'd2,  k: 32'd8,  addr: 42'h20,            lines: 1};
    vecs[3] = '{m: 32'd5,  k: 32'd16, addr: 42'h500,           lines: 5};
    vecs[4] = '{m: 32'd16, k: 32'd3,  addr: 42'h77,            lines: 3};
    vecs[5] = '{m: 32'd7,  k: 32'd7,  addr: 42'hABC,           lines: 3};

    reset = 1'b0;
    bus.run = 1'b0;
    bus.M = '0;
    bus.K = '0;
    bus.first_clAddr = '0;
    bus.c0TxAlmFull = 1'b0;
    bus.buffer_used = '0;
    repeat (3) step();

    chk("rst done", 512'(bus.done), 512'(1));
    chk("rst c0TxValid", 512'(bus.c0TxValid), 512'(0));
    chk("rst wr_en", 512'(bus.buffer_wr_enable), 512'(0));
    chk("rst hdr", 512'(bus.reqMemHdr), 512'(0));
    chk("rst wr_data", bus.buffer_wr_data, 512'(0));
    reset = 1'b1;
    repeat (2) step();

    // Table-driven transfers.
    foreach (vecs[v]) begin
      br = req_addr.size();
      bp = push_data.size();
      pulse_run(vecs[v].m, vecs[v].k, vecs[v].addr);
      wait_done($sformatf("vec%0d", v), 200);
      repeat (3) step();
      chk_lines($sformatf("vec%0d", v), br, bp, vecs[v].addr, vecs[v].lines);
      if (req_cyc.size() - br == vecs[v].lines)
        for (int i = 1; i < vecs[v].lines; i++)
          chk($sformatf("vec%0d back2back%0d", v, i), 512'(req_cyc[br+i]), 512'(req_cyc[br+i-1] + 1));
    end

    // Zero-length run: one cycle of RUN, nothing issued.
    br = req_addr.size();
    bp = push_data.size();
    dl = done_low_cnt;
    pulse_run(32'd3, 32'd5, 42'h900);
    repeat (6) step();
    chk("zero done_low", 512'(done_low_cnt - dl), 512'(1));
    chk("zero reqs", 512'(req_addr.size() - br), 512'(0));
    chk("zero pushes", 512'(push_data.size() - bp), 512'(0));

    // Almost-full hold for 20 cycles.
    br = req_addr.size();
    bp = push_data.size();
    bus.c0TxAlmFull = 1'b1;
    pulse_run(32'd2, 32'd16, 42'h2000);
    repeat (19) step();
    chk("almfull hold reqs", 512'(req_addr.size() - br), 512'(0));
    bus.c0TxAlmFull = 1'b0;
    rel = cyc;
    wait_done("almfull", 200);
    repeat (3) step();
    chk_lines("almfull", br, bp, 42'h2000, 2);
    if (req_cyc.size() - br > 0)
      chk("almfull first_req", 512'(req_cyc[br]), 512'(rel + 1));

    // Buffer occupancy back-pressure with responses withheld.
    br = req_addr.size();
    bp = push_data.size();
    bus.buffer_used = CNT_W'(6);
    rsp_en = 1'b0;
    pulse_run(32'd16, 32'd16, 42'h4000);
    repeat (15) step();
    chk("bp stall reqs", 512'(req_addr.size() - br), 512'(2));
    chk("bp stall pushes", 512'(push_data.size() - bp), 512'(0));
    bus.buffer_used = '0;
    rsp_en = 1'b1;
    max_occ = 0;
    for (int n = 0; n < 300 && !bus.done; n++) begin
      step();
      occ = (req_addr.size() - br) - (push_data.size() - bp) + int'(bus.buffer_used);
      if (occ > max_occ) max_occ = occ;
    end
    chk("bp done", 512'(bus.done), 512'(1));
    repeat (3) step();
    chk_lines("bp", br, bp, 42'h4000, 16);
    chk("bp max_inflight_ok", 512'(max_occ <= DEPTH), 512'(1));

    // Reset in the middle of a run.
    br = req_addr.size();
    bp = push_data.size();
    pulse_run(32'd8, 32'd16, 42'h6000);
    repeat (3) step();
    chk("abort pre reqs", 512'(req_addr.size() - br), 512'(3));
    chk("abort pre c0TxValid", 512'(bus.c0TxValid), 512'(1));
    reset = 1'b0;
    #1;
    chk("abort c0TxValid", 512'(bus.c0TxValid), 512'(0));
    chk("abort wr_en", 512'(bus.buffer_wr_enable), 512'(0));
    chk("abort done", 512'(bus.done), 512'(1));
    repeat (2) step();
    reset = 1'b1;
    repeat (12) step();
    chk("abort late pushes", 512'(push_data.size() - bp), 512'(0));
    chk("abort reqs", 512'(req_addr.size() - br), 512'(3));
    chk("abort idle", 512'(bus.done), 512'(1));

    // Second run pulse during RUN is ignored; a write response is ignored.
    br = req_addr.size();
    bp = push_data.size();
    pulse_run(32'd2, 32'd16, 42'h8000);
    pulse_run(32'd4, 32'd16, 42'h9000);
    inject_req++;
    wait_done("rerun", 200);
    repeat (3) step();
    chk_lines("rerun", br, bp, 42'h8000, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
